// File: rtl/apb_regs_pkg.sv
// Shared encodings, FSM states and type helpers for the
// parametrised APB control/status register bank.
package apb_regs_pkg;

    localparam logic [3:0] ZR     = 4'd0;
    localparam logic [3:0] RO     = 4'd1;
    localparam logic [3:0] RW_0   = 4'd2;
    localparam logic [3:0] RW_1   = 4'd3;
    localparam logic [3:0] RWE_0  = 4'd4;
    localparam logic [3:0] RWE_1  = 4'd5;
    localparam logic [3:0] RW1E_0 = 4'd6;
    localparam logic [3:0] RW1E_1 = 4'd7;
    localparam logic [3:0] W1C    = 4'd8;
    localparam logic [3:0] W1O    = 4'd9;
    localparam logic [3:0] RWC    = 4'd10;
    localparam logic [3:0] RC     = 4'd11;

    localparam int MAX_TYPES_W = 256 * 32 * 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    function automatic logic [3:0] bit_type(
        input logic [MAX_TYPES_W-1:0] types,
        input int r,
        input int b
    );
        return types[(r*32+b)*4 +: 4];
    endfunction

    function automatic logic rst_val(input logic [3:0] t);
        return (t == RW_1) || (t == RWE_1) || (t == RW1E_1);
    endfunction

endpackage

// File: rtl/apb_csr_bank_if.sv
// APB3/APB4 slave-side bus bundle for the CSR bank.
interface apb_csr_bank_if #(
    parameter int APB_WIDTH = 12
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [APB_WIDTH-1:0] paddr;
    logic [3:0]           pstrb;
    logic [31:0]          pwdata;
    logic [2:0]           pprot;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr,
        output pstrb, pwdata, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        input  pstrb, pwdata, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_csr_bit.sv
// One register bit cell; behaviour fixed at elaboration by TYPE.
module apb_csr_bit
    import apb_regs_pkg::*;
#(
    parameter logic [3:0] TYPE = RW_0
) (
    input  logic clk,
    input  logic resetn,
    input  logic wr_en,
    input  logic wdata,
    input  logic rd_en,
    input  logic ext_in,
    output logic q_out,
    output logic rd_val,
    output logic flag
);

    logic bit_q, bit_d;

    // Flag types let the hardware set win over any clear.
    always_comb begin
        bit_d  = bit_q;
        q_out  = bit_q;
        rd_val = bit_q;
        flag   = 1'b0;
        case (TYPE)
            RW_0, RW_1: begin
                if (wr_en) bit_d = wdata;
            end
            RWE_0, RWE_1: begin
                if (wr_en) bit_d = wdata;
                rd_val = ext_in;
            end
            RW1E_0, RW1E_1: begin
                if (wr_en) bit_d = wdata;
                if (ext_in) bit_d = 1'b1;
            end
            W1C: begin
                if (wr_en && wdata) bit_d = 1'b0;
                if (ext_in) bit_d = 1'b1;
                flag = bit_q;
            end
            W1O: begin
                bit_d  = wr_en && wdata;
                rd_val = 1'b0;
            end
            RWC: begin
                if (wr_en) bit_d = wdata;
                if (ext_in) bit_d = 1'b0;
            end
            RC: begin
                if (rd_en) bit_d = 1'b0;
                if (ext_in) bit_d = 1'b1;
                q_out = 1'b0;
                flag  = bit_q;
            end
            RO: begin
                bit_d  = 1'b0;
                q_out  = 1'b0;
                rd_val = ext_in;
            end
            default: begin
                bit_d  = 1'b0;
                q_out  = 1'b0;
                rd_val = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) bit_q <= rst_val(TYPE);
        else         bit_q <= bit_d;
    end

endmodule

// File: rtl/apb_csr_bank.sv
// Parametrised APB CSR bank: access FSM, decode, error
// response, read mux, strobes, irq and the bit-cell array.
module apb_csr_bank
    import apb_regs_pkg::*;
#(
    parameter int REGS_NUM    = 8,
    parameter int APB_WIDTH   = 12,
    parameter int WAIT_STATES = 0,
    parameter logic [REGS_NUM*128-1:0] REG_TYPES =
        {(REGS_NUM*32){RW_0}},
    parameter logic [REGS_NUM-1:0]    PRIV_MASK = '0,
    parameter logic [REGS_NUM*32-1:0] IRQ_MASK  = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    apb_csr_bank_if.slave          apb,
    output logic [REGS_NUM*32-1:0] reg_outputs,
    input  logic [REGS_NUM*32-1:0] reg_inputs,
    output logic [REGS_NUM-1:0]    reg_wr_stb,
    output logic [REGS_NUM-1:0]    reg_rd_stb,
    output logic                   irq
);

    localparam int IW = APB_WIDTH - 2;
    localparam int RW = (REGS_NUM > 1) ? $clog2(REGS_NUM) : 1;
    localparam logic [3:0] CW = 4'(WAIT_STATES);
    localparam logic [IW:0] NREG = (IW+1)'(REGS_NUM);

    apb_state_e state_q, state_d, cur;
    logic [3:0] cnt_q, cnt_d;
    logic [REGS_NUM-1:0] wr_stb_q, wr_stb_d;
    logic [REGS_NUM-1:0] rd_stb_q, rd_stb_d;
    logic irq_q, irq_d;

    logic [IW-1:0] idx;
    logic [RW-1:0] ridx;
    logic idx_ok, bad, stray, rdy;
    logic commit, wr_go, rd_go;
    logic [REGS_NUM*32-1:0] rd_flat;
    logic [REGS_NUM*32-1:0] flags;
    logic unused_bits;

    assign idx    = apb.paddr[APB_WIDTH-1:2];
    assign ridx   = idx[RW-1:0];
    assign idx_ok = {1'b0, idx} < NREG;
    assign unused_bits = ^{apb.pprot[2:1], apb.paddr[1:0]};

    // Bus phase of the current cycle; state_q remembers whether
    // the previous cycle opened or continued a transfer.
    always_comb begin
        cur = IDLE;
        if (apb.psel && !apb.penable)
            cur = SETUP;
        else if (apb.psel && state_q != IDLE)
            cur = ACCESS;
    end

    assign stray = apb.psel && apb.penable && state_q == IDLE;
    assign bad   = !idx_ok || (PRIV_MASK[ridx] && !apb.pprot[0]);
    assign rdy   = (cur == ACCESS) && (cnt_q == CW);

    assign apb.pready  = resetn && (rdy || stray);
    assign apb.pslverr = resetn && (stray || (rdy && bad));

    assign commit = resetn && rdy && !bad;
    assign wr_go  = commit && apb.pwrite;
    assign rd_go  = commit && !apb.pwrite;

    assign apb.prdata = rd_go ? rd_flat[{ridx, 5'b00000} +: 32] : '0;

    always_comb begin
        state_d  = cur;
        cnt_d    = '0;
        wr_stb_d = '0;
        rd_stb_d = '0;
        if (cur == ACCESS) begin
            if (rdy) state_d = IDLE;
            else     cnt_d   = cnt_q + 4'd1;
        end
        if (wr_go) wr_stb_d[ridx] = 1'b1;
        if (rd_go) rd_stb_d[ridx] = 1'b1;
        irq_d = |(flags & IRQ_MASK);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_stb_q <= '0;
            rd_stb_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_stb_q <= wr_stb_d;
            rd_stb_q <= rd_stb_d;
            irq_q    <= irq_d;
        end
    end

    assign reg_wr_stb = wr_stb_q;
    assign reg_rd_stb = rd_stb_q;
    assign irq        = irq_q;

    for (genvar r = 0; r < REGS_NUM; r++) begin : g_reg
        logic sel;
        assign sel = (ridx == RW'(r));
        for (genvar b = 0; b < 32; b++) begin : g_bit
            localparam logic [3:0] T =
                bit_type(MAX_TYPES_W'(REG_TYPES), r, b);
            apb_csr_bit #(.TYPE(T)) u_bit (
                .clk    (clk),
                .resetn (resetn),
                .wr_en  (wr_go && sel && apb.pstrb[b/8]),
                .wdata  (apb.pwdata[b]),
                .rd_en  (rd_go && sel),
                .ext_in (reg_inputs[r*32+b]),
                .q_out  (reg_outputs[r*32+b]),
                .rd_val (rd_flat[r*32+b]),
                .flag   (flags[r*32+b])
            );
        end
    end

endmodule

// File: tb/tb_apb_csr_bank.sv
// Directed bench for apb_csr_bank with a register-level model
// checked every cycle plus literal spot checks.
module tb_apb_csr_bank;
    import apb_regs_pkg::*;

    localparam int WS = 2;
    localparam logic [31:0] RC_M  = 32'h1;
    localparam logic [31:0] W1C_M = 32'h2;
    localparam logic [31:0] FLG_M = 32'h3;
    localparam logic [255:0] IRQM = {160'b0, 32'h3, 64'b0};

    function automatic logic [1023:0] mk_types();
        logic [1023:0] t;
        for (int i = 0; i < 256; i++) t[i*4 +: 4] = RW_0;
        t[(2*32+0)*4 +: 4] = RC;
        t[(2*32+1)*4 +: 4] = W1C;
        for (int b = 0; b < 8; b++) t[(4*32+b)*4 +: 4] = RW_1;
        return t;
    endfunction

    localparam logic [1023:0] TYPES = mk_types();

    logic clk = 1'b0;
    logic resetn;
    logic [255:0] reg_outputs, reg_inputs;
    logic [7:0] reg_wr_stb, reg_rd_stb;
    logic irq;

    apb_csr_bank_if #(.APB_WIDTH(12)) bus ();

    apb_csr_bank #(
        .REGS_NUM    (8),
        .APB_WIDTH   (12),
        .WAIT_STATES (WS),
        .REG_TYPES   (TYPES),
        .PRIV_MASK   (8'h08),
        .IRQ_MASK    (IRQM)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .apb         (bus),
        .reg_outputs (reg_outputs),
        .reg_inputs  (reg_inputs),
        .reg_wr_stb  (reg_wr_stb),
        .reg_rd_stb  (reg_rd_stb),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: plain register values, the reg-2 flag word and the
    // strobe/irq expectations, advanced once per clock.
    logic [7:0][31:0] m_val, n_val;
    logic [31:0] m_flag, n_flag;
    logic [7:0] m_wr, n_wr, m_rd, n_rd;
    logic m_irq, n_irq;

    logic p_go = 1'b0;
    logic p_wr = 1'b0;
    logic [2:0] p_idx = '0;
    logic [31:0] p_data = '0;
    logic [3:0] p_strb = '0;

    always_comb begin
        logic [31:0] lm;
        lm = {{8{p_strb[3]}}, {8{p_strb[2]}},
              {8{p_strb[1]}}, {8{p_strb[0]}}};
        n_val  = m_val;
        n_flag = m_flag;
        n_wr   = '0;
        n_rd   = '0;
        n_irq  = |(m_flag & FLG_M);
        if (p_go && p_wr) begin
            n_val[p_idx] = (m_val[p_idx] & ~lm) | (p_data & lm);
            if (p_idx == 3'd2) begin
                n_val[2] = n_val[2] & ~FLG_M;
                n_flag = m_flag & ~(p_data & lm & W1C_M);
            end
            n_wr[p_idx] = 1'b1;
        end else if (p_go) begin
            if (p_idx == 3'd2) n_flag = m_flag & ~RC_M;
            n_rd[p_idx] = 1'b1;
        end
        n_flag = n_flag | (reg_inputs[95:64] & FLG_M);
        if (!resetn) begin
            n_val    = '0;
            n_val[4] = 32'h0000_00FF;
            n_flag   = '0;
            n_wr     = '0;
            n_rd     = '0;
            n_irq    = 1'b0;
        end
    end

    always @(posedge clk) begin
        m_val  <= n_val;
        m_flag <= n_flag;
        m_wr   <= n_wr;
        m_rd   <= n_rd;
        m_irq  <= n_irq;
    end

    function automatic logic [31:0] m_out(input int r);
        return m_val[r] | ((r == 2) ? (m_flag & W1C_M) : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input int r);
        return m_val[r] | ((r == 2) ? m_flag : 32'h0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < 8; r++)
                chk($sformatf("reg_out%0d", r),
                    reg_outputs[r*32 +: 32], m_out(r));
            chk("wr_stb", 32'(reg_wr_stb), 32'(m_wr));
            chk("rd_stb", 32'(reg_rd_stb), 32'(m_rd));
            chk("irq", 32'(irq), 32'(m_irq));
            if (!resetn) chk("pready_rst", 32'(bus.pready), 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(
        input  logic        wr,
        input  logic [11:0] addr,
        input  logic [31:0] data,
        input  logic [3:0]  strb,
        input  logic [2:0]  prot,
        input  logic        hold,
        input  logic        setpulse,
        output logic [31:0] rdata,
        output logic        err
    );
        int idx;
        logic exp_err;
        idx = int'(addr[11:2]);
        exp_err = (idx >= 8) || (idx == 3 && !prot[0]);
        rdata = '0;
        err = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.pstrb   = strb;
        bus.pprot   = prot;
        tick();
        bus.penable = 1'b1;
        for (int k = 0; k <= WS; k++) begin
            if (k == WS) begin
                p_go   = !exp_err;
                p_wr   = wr;
                p_idx  = idx[2:0];
                p_data = data;
                p_strb = strb;
                if (setpulse) reg_inputs[64] = 1'b1;
            end
            @(negedge clk);
            chk("pready", 32'(bus.pready), 32'(k == WS));
            if (k == WS) begin
                chk("pslverr", 32'(bus.pslverr), 32'(exp_err));
                chk("prdata", bus.prdata,
                    (exp_err || wr) ? 32'h0 : m_read(idx));
                rdata = bus.prdata;
                err = bus.pslverr;
            end
            tick();
        end
        p_go = 1'b0;
        if (setpulse) reg_inputs[64] = 1'b0;
        bus.penable = 1'b0;
        if (!hold) bus.psel = 1'b0;
    endtask

    task automatic pulse(input int bitn);
        reg_inputs[bitn] = 1'b1;
        tick();
        reg_inputs[bitn] = 1'b0;
    endtask

    logic [31:0] rd;
    logic er;

    initial begin
        resetn = 1'b0;
        reg_inputs = '0;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
        bus.paddr = '0;
        bus.pwdata = '0;
        bus.pstrb = '0;
        bus.pprot = '0;
        tick();
        chk_en = 1'b1;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_reg4", reg_outputs[159:128], 32'h0000_00FF);
        chk("rst_irq", 32'(irq), 32'h0);
        tick();

        xfer(1, 12'h004, 32'hDEAD_BEEF, 4'b0101, 3'b000, 0, 0, rd, er);
        @(negedge clk);
        chk("wr_reg1", reg_outputs[63:32], 32'h00AD_00EF);
        chk("wr_stb1", 32'(reg_wr_stb), 32'h02);
        tick();
        @(negedge clk);
        chk("wr_stb1_clr", 32'(reg_wr_stb), 32'h00);
        tick();

        xfer(0, 12'h024, 32'h0, 4'b0000, 3'b000, 0, 0, rd, er);
        chk("oob_err", 32'(er), 32'h1);
        chk("oob_rd", rd, 32'h0);
        @(negedge clk);
        chk("oob_stb", 32'(reg_rd_stb | reg_wr_stb), 32'h0);
        tick();

        xfer(1, 12'h00C, 32'h0000_00A5, 4'hF, 3'b000, 0, 0, rd, er);
        chk("priv_err", 32'(er), 32'h1);
        @(negedge clk);
        chk("priv_keep", reg_outputs[127:96], 32'h0);
        tick();
        xfer(1, 12'h00C, 32'h0000_00A5, 4'hF, 3'b001, 0, 0, rd, er);
        chk("priv_ok", 32'(er), 32'h0);
        @(negedge clk);
        chk("priv_wr", reg_outputs[127:96], 32'h0000_00A5);
        tick();

        pulse(64);
        @(negedge clk);
        chk("irq_lat1", 32'(irq), 32'h0);
        tick();
        @(negedge clk);
        chk("irq_lat2", 32'(irq), 32'h1);
        tick();
        xfer(0, 12'h008, 32'h0, 4'h0, 3'b000, 0, 0, rd, er);
        chk("rc_rd1", rd, 32'h1);
        @(negedge clk);
        chk("irq_hold", 32'(irq), 32'h1);
        tick();
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'h0);
        tick();
        pulse(64);
        tick();
        xfer(0, 12'h008, 32'h0, 4'h0, 3'b000, 0, 1, rd, er);
        chk("rc_setwin_rd", rd, 32'h1);
        xfer(0, 12'h008, 32'h0, 4'h0, 3'b000, 0, 0, rd, er);
        chk("rc_still_set", rd, 32'h1);
        xfer(0, 12'h008, 32'h0, 4'h0, 3'b000, 0, 0, rd, er);
        chk("rc_cleared", rd, 32'h0);

        pulse(65);
        tick();
        @(negedge clk);
        chk("w1c_set", reg_outputs[95:64], 32'h2);
        tick();
        xfer(1, 12'h008, 32'h2, 4'h1, 3'b000, 0, 0, rd, er);
        @(negedge clk);
        chk("w1c_clr", reg_outputs[95:64], 32'h0);
        tick();

        bus.psel = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite = 1'b1;
        bus.paddr = 12'h000;
        bus.pwdata = 32'hFFFF_FFFF;
        bus.pstrb = 4'hF;
        @(negedge clk);
        chk("stray_rdy", 32'(bus.pready), 32'h1);
        chk("stray_err", 32'(bus.pslverr), 32'h1);
        tick();
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        tick();

        xfer(1, 12'h000, 32'h1234_5678, 4'hF, 3'b000, 1, 0, rd, er);
        xfer(0, 12'h000, 32'h0, 4'h0, 3'b000, 0, 0, rd, er);
        chk("b2b_rd", rd, 32'h1234_5678);
        tick();

        bus.psel = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite = 1'b1;
        bus.paddr = 12'h010;
        bus.pwdata = 32'hCAFE_F00D;
        bus.pstrb = 4'hF;
        tick();
        bus.penable = 1'b1;
        @(negedge clk);
        chk("rstw_wait", 32'(bus.pready), 32'h0);
        tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("rstw_rdy0", 32'(bus.pready), 32'h0);
        tick();
        @(negedge clk);
        chk("rstw_rdy1", 32'(bus.pready), 32'h0);
        tick();
        resetn = 1'b1;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        tick();
        xfer(0, 12'h010, 32'h0, 4'h0, 3'b000, 0, 0, rd, er);
        chk("rstw_reg4", rd, 32'h0000_00FF);
        xfer(0, 12'h000, 32'h0, 4'h0, 3'b000, 0, 0, rd, er);
        chk("rstw_reg0", rd, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_csr_bank.md
# apb_csr_bank

Parametrised APB3/APB4 control/status register bank, the successor of the fixed four-register APB bank. It is generalised to REGS_NUM registers with a flat packed register bus. It adds programmable wait states, PSLVERR on bad/privileged accesses, per-register access strobes, a read-clear flag type and a registered interrupt output. It sits between the peripheral APB slave port and the block's datapath control/status bits.

## Interface
- REGS_NUM, 8, number of 32-bit registers (1..256)
- APB_WIDTH, 12, paddr width; register index = paddr[APB_WIDTH-1:2]
- WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15)
- REG_TYPES, all RW_0, 4 bits per register bit, bit b of register r at [(r*32+b)*4 +: 4]
- PRIV_MASK, 0, REGS_NUM bits; set bit = register requires apb_pprot[0]=1
- IRQ_MASK, 0, REGS_NUM*32 bits; W1C/RC flag bits contributing to irq
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- apb_psel, apb_penable, apb_pwrite  in  1  APB controls
- apb_paddr  in  APB_WIDTH  address
- apb_pstrb  in  4  byte strobes
- apb_pwdata  in  32  write data
- apb_pprot  in  3  protection; only bit 0 (privileged) used
- apb_prdata  out  32  read data
- apb_pready  out  1  transfer complete
- apb_pslverr  out  1  transfer error, valid with pready
- reg_outputs  out  REGS_NUM*32  register values to datapath
- reg_inputs  in  REGS_NUM*32  status/enable/set/clear inputs from datapath
- reg_wr_stb  out  REGS_NUM  one-cycle pulse, register r written
- reg_rd_stb  out  REGS_NUM  one-cycle pulse, register r read
- irq  out  1  OR of masked flag bits

## Operation
- Bit types: ZR, RO, RW_0/RW_1, RWE_0/1, RW1E_0/1, W1C, W1O, RWC keep their existing semantics; new RC=11: flag set by reg_inputs bit, cleared by a successful read of the register, set wins over clear, reg_outputs bit 0.
- Commit point moved to the APB access phase: a write takes effect on the edge where psel & penable & pready & ~pslverr; only lanes with pstrb set change.
- Error (pslverr=1 with pready): index >= REGS_NUM, or PRIV_MASK[index]=1 and pprot[0]=0. Errored transfers write nothing, return prdata=0, produce no strobes, do not clear RC bits.
- reg_wr_stb[r]/reg_rd_stb[r]: registered, high for exactly one cycle after a successful write/read commit of register r.
- irq: registered OR over (flag & IRQ_MASK) of all W1C and RC bits.
- FSM: IDLE -> SETUP (psel & ~penable) -> ACCESS (penable); ACCESS stays while pready=0; ACCESS -> SETUP if psel still high after completion (back-to-back), else IDLE. penable seen in IDLE is ignored (no write, pready=1, pslverr=1).

## Timing
- Wait counter: cleared in SETUP, increments each ACCESS cycle with pready=0; pready = (state==ACCESS) & (cnt==WAIT_STATES). WAIT_STATES=0 gives a two-cycle APB transfer.
- apb_prdata combinational from register bank while ACCESS & ~pwrite & pready, else 0.
- Register and flag updates visible on reg_outputs/prdata one cycle after commit; strobes and irq have 1-cycle latency.
- Simultaneous set input and W1C/RC clear: set wins.
- Reset (resetn=0 sampled on an edge): FSM to IDLE, cnt=0, registers to type reset values (RW_1/RWE_1/RW1E_1 = 1, others 0), strobes 0, irq 0. A transfer in progress is abandoned without commit. While resetn=0, pready=0.

## Structure
- Extend apb_regs_pkg: add RC=11 localparam, FSM state enum (IDLE, SETUP, ACCESS), function for type lookup from REG_TYPES.
- Sub-module apb_csr_bit: one bit cell parametrised by type, with inputs wr_en, wdata, rd_en, ext_in, outputs q_out, rd_val, flag; top generates REGS_NUM*32 instances plus FSM, decode, error logic and read mux.

## Test plan
- WAIT_STATES=2, write 0xDEADBEEF to reg 1 strb=4'b0101 -> pready high on 3rd access cycle, reg_outputs[63:32]=0x00AD00EF next cycle, reg_wr_stb=8'h02 for one cycle.
- Read paddr index 9 with REGS_NUM=8 -> pready=1, pslverr=1, prdata=0, no strobes.
- PRIV_MASK[3]=1, write with pprot=3'b000 -> pslverr=1, reg 3 unchanged; repeat pprot=3'b001 -> write commits.
- RC bit reg 2 bit 0, IRQ_MASK set: pulse input -> irq=1 after 2 cycles; read reg 2 -> prdata bit0=1, irq=0 two cycles later; read with coincident set pulse -> bit stays 1.
- Back-to-back write then read of reg 0 with psel held -> read returns new value, FSM ACCESS->SETUP without IDLE.
- resetn low during wait state of a write -> no commit, RW_1 bits read back 1, pready=0 during reset.
